// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
// Sequence-check feature is enabled by FIFO_RD_STREAM_SEQ_CHECK_EN.
package fifo_rd_pkg;

  localparam int unsigned BufDepthMin = 3;
  localparam int unsigned BufDepthMax = 8;
  localparam int unsigned ErrCntW     = 16;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of an index into a depth-entry array; never below 1.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Next expected word of an incrementing sequence, modulo 2^w.
  function automatic logic [63:0] seq_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v + 64'd1) & mask;
  endfunction

endpackage

// File: rtl/fifo_rd_ring_buf.sv
// Prefetch ring buffer: storage, wrapping read/write pointers and occupancy count.
module fifo_rd_ring_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  wdata,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  rdata,
  output logic [cnt_width(BUF_DEPTH)-1:0]   count
);

  localparam int unsigned CntW = cnt_width(BUF_DEPTH);
  localparam int unsigned PtrW = ptr_width(BUF_DEPTH);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  // Storage is cleared so the head reads as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port to valid/ready stream adapter with a small prefetch buffer.
// Define FIFO_RD_STREAM_SEQ_CHECK_EN to add the seq_err/err_cnt sequence checker.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rempty,
  input  logic [WIDTH-1:0]                  rdata,
  output logic                              rinc,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [WIDTH-1:0]                  m_data,
  output logic [cnt_width(BUF_DEPTH)-1:0]   level
`ifdef FIFO_RD_STREAM_SEQ_CHECK_EN
  ,
  output logic                              seq_err,
  output logic [ErrCntW-1:0]                err_cnt
`endif
);

  localparam int unsigned CntW = cnt_width(BUF_DEPTH);

  if (BUF_DEPTH < BufDepthMin || BUF_DEPTH > BufDepthMax) begin : g_bad_depth
    $error("fifo_rd_stream: BUF_DEPTH out of range");
  end

  logic            inflight_q, inflight_d;
  logic [CntW-1:0] count;
  logic [CntW:0]   occupancy;
  logic            pop;

  // Issue decision uses only registered state and rempty, never m_ready.
  always_comb begin
    occupancy  = {1'b0, count} + (CntW + 1)'(inflight_q);
    rinc       = rst_n & ~rempty & (occupancy < (CntW + 1)'(BUF_DEPTH));
    inflight_d = rinc & ~rempty;
    m_valid    = (count != '0);
    pop        = m_valid & m_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= inflight_d;
  end

  fifo_rd_ring_buf #(
    .WIDTH     (WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_ring_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .wdata (rdata),
    .pop   (pop),
    .rdata (m_data),
    .count (count)
  );

  assign level = count;

`ifdef FIFO_RD_STREAM_SEQ_CHECK_EN
  logic               seeded_q;
  logic [WIDTH-1:0]   exp_q;
  logic               seq_err_q;
  logic [ErrCntW-1:0] err_cnt_q;
  logic               mismatch;

  assign mismatch = pop & seeded_q & (m_data != exp_q);

  // Expected value re-syncs to each popped word so one glitch counts once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seeded_q  <= 1'b0;
      exp_q     <= '0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (pop) begin
        seeded_q <= 1'b1;
        exp_q    <= WIDTH'(seq_inc(64'(m_data), WIDTH));
      end
      if (mismatch) begin
        seq_err_q <= 1'b1;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ErrCntW'(1);
      end
    end
  end

  assign seq_err = seq_err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the team's dual-clock FIFO (ports winc/rinc/wdata/rdata/wfull/rempty); lives entirely in the FIFO read clock domain.
- Drives the FIFO read port (rinc/rempty/rdata, 1-cycle registered read latency) and re-presents the words as a valid/ready stream.
- Uses a small prefetch buffer to sustain 1 word/cycle through downstream backpressure.
- Complements the write-side stimulus and producer logic already built around the FIFO.

Parameters:
- WIDTH, 8, data word width; must match FIFO WIDTH.
- BUF_DEPTH, 3, prefetch buffer entries; legal range 3..8. 3 is the minimum for full throughput.

Ports:
- clk  in  1  read-domain clock, same as the FIFO rclk.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- rempty  in  1  FIFO empty flag.
- rdata  in  WIDTH  FIFO read data, valid the cycle after an accepted rinc.
- rinc  out  1  FIFO read request.
- m_valid  out  1  output word available.
- m_ready  in  1  downstream accepts the word.
- m_data  out  WIDTH  output word; head of the buffer.
- level  out  $clog2(BUF_DEPTH+1)  words currently held in the buffer.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - count=0, inflight=0, rd_ptr=wr_ptr=0, m_valid=0, m_data=0, level=0.
  - rinc is forced to 0 while rst_n=0.
- inflight flag:
  - Next value is rinc & ~rempty, i.e. a read was issued last cycle.
- rinc:
  - rinc = ~rempty & ((count + inflight) < BUF_DEPTH).
  - Decoded from registered state plus rempty only. No combinational path from m_ready.
- Capture:
  - When inflight=1, rdata is written to buf[wr_ptr] and wr_ptr advances.
  - wr_ptr wraps from BUF_DEPTH-1 to 0.
- Output:
  - m_valid = (count != 0).
  - m_data = buf[rd_ptr], registered-storage read.
  - Pop on m_valid & m_ready; rd_ptr advances with the same wrap rule.
- Count update:
  - count_next = count + inflight - pop.
  - Simultaneous capture and pop leaves count unchanged.
- Invariant: count + inflight <= BUF_DEPTH at all times, so the buffer never overflows.
- Handshake rules:
  - m_data is held stable while m_valid=1 and m_ready=0.
  - m_valid is never deasserted without a pop.
- Latency:
  - An idle block seeing rempty fall at cycle N asserts rinc at N.
  - Data is captured at N+1; m_valid=1 from N+2.
- Throughput: with m_ready=1 and the FIFO non-empty, steady state is 1 word/cycle (count=1, inflight=1).
- Backpressure:
  - With m_ready=0, the block prefetches until count=BUF_DEPTH, then holds rinc=0.
  - When m_ready returns, reads resume in the same cycle count+inflight drops below BUF_DEPTH.
- rempty rising while inflight=1: the in-flight word is still captured; no further reads are issued.
- Reset mid-operation:
  - An in-flight word is discarded, and buffered words are discarded.
  - The system resets the FIFO read side together with this block.
- level = count.

Optional Feature:
- Macro: FIFO_RD_STREAM_SEQ_CHECK_EN.
- With the macro defined, the block checks that consecutive popped words increment by 1 modulo 2^WIDTH, and adds two ports:
  - seq_err  out  1  sticky; set on the first mismatch and cleared only by reset.
  - err_cnt  out  16  mismatch count; saturates at 16'hFFFF.
- The first pop after reset only seeds the expected value; it is never flagged.
- Without the macro: no extra ports and no extra logic.

Decomposition:
- Package fifo_rd_pkg holds:
  - the BUF_DEPTH range limits;
  - the count and pointer width functions, with $clog2 helpers;
  - the err_cnt width constant;
  - the SEQ check expected-value increment helper.
- One natural sub-module, fifo_rd_ring_buf:
  - storage array, wr_ptr/rd_ptr with wrap, and count;
  - parameterised by WIDTH and BUF_DEPTH.
- The top level holds the rinc/inflight issue logic and the optional checker.

Test Plan:
1. Reset and first word: rst_n=0 for 3 cycles, rempty=1 → rinc=0, m_valid=0, level=0. Release reset, drop rempty with rdata=8'h00 → rinc at N, m_valid=1 with m_data=8'h00 at N+2.
2. Streaming: FIFO model preloaded with 8'h00..8'h0F, m_ready=1 → 16 pops on 16 consecutive cycles, data 00..0F in order; rinc deasserts the cycle rempty rises; level ends at 0.
3. Backpressure: m_ready=0 with the FIFO holding 10 words → exactly 3 rinc pulses, level=3, m_data stays 8'h00. Raise m_ready → remaining 7 words follow with no gaps or duplicates.
4. Boundary: rempty rises in the same cycle as an accepted read → that word is captured, no extra rinc. Simultaneous capture and pop at level=1 → level stays 1.
5. Reset mid-stream: assert rst_n=0 with level=2 and inflight=1 → next cycle m_valid=0, level=0, rinc=0; after release, reading restarts cleanly.
6. FIFO_RD_STREAM_SEQ_CHECK_EN: popped stream 00,01,02,05,06 → seq_err rises on the pop of 05 and stays high, err_cnt=1. Without the macro, the same stream compiles and passes with no seq_err port.
